fifo_last_sched: RTL and testbench

- Clocked scheduler that shares one self-timed tail FIFO stage among N_REQ requesters.
- The stage accepts a token on a drive event. It reports acceptance with a free event and completion with a fire event.
- Round-robin arbitrates requesters and issues drive events.
- Waits for free before issuing the next drive; tracks tokens in flight via fire events; flags protocol errors.

---
 rtl/fifo_last_sched_pkg.sv | 13 +
 rtl/fifo_last_sched_event.sv | 25 ++
 rtl/fifo_last_sched.sv | 142 ++++++++++++++
 tb/tb_fifo_last_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_last_sched_pkg.sv
// rtl/fifo_last_sched_pkg.sv - shared widths and FSM state codes for fifo_last_sched
`timescale 1ns/1ps
package fifo_last_sched_pkg;
  localparam int CNT_W  = 16;
  localparam int INFL_W = 4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ARB       = 3'd1;
  localparam state_t ST_DRIVE     = 3'd2;
  localparam state_t ST_WAIT_FREE = 3'd3;
  localparam state_t ST_HALT      = 3'd4;
endpackage

// File: rtl/fifo_last_sched_event.sv
// rtl/fifo_last_sched_event.sv - event_sync2p: 2-FF synchronizer plus history flop
// Turns every level change of a two-phase input into a one-cycle event pulse.
`timescale 1ns/1ps
module event_sync2p (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_evt
);
  logic r_s1, r_s2, r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_s1   <= i_lvl;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_evt = r_s2 ^ r_hist;
endmodule

// File: rtl/fifo_last_sched.sv
// rtl/fifo_last_sched.sv - round-robin scheduler feeding one self-timed FIFO tail stage
// Optional per-requester grant counters: define FIFO_LAST_SCHED_STATS_EN.
`timescale 1ns/1ps
module fifo_last_sched
  import fifo_last_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_drive,
  input  logic                     i_free,
  input  logic                     i_fire,
  output logic [INFL_W-1:0]        o_inflight,
  output logic                     o_busy,
  output logic                     o_err_timeout,
  output logic                     o_err_underflow,
  input  logic                     i_clr_err,
  output logic [CNT_W*N_REQ-1:0]   o_grant_cnt
);
  localparam int PTR_W = $clog2(N_REQ);

  // First set request after ptr, wrapping; scanning offsets downwards lets the nearest win.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] w_sel;
    int               idx;
    w_sel = ptr;
    for (int s = N_REQ; s >= 1; s--) begin
      idx = (int'(ptr) + s) % N_REQ;
      if (req[idx]) w_sel = PTR_W'(idx);
    end
    return w_sel;
  endfunction

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr, r_winner;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_drive;
  logic [INFL_W-1:0]  r_inflight;
  logic [15:0]        r_tmo;
  logic               r_err_timeout, r_err_underflow;
  logic               w_free_evt, w_fire_evt, w_inc, w_dec;
  logic [16:0]        w_tmo_nxt;

  event_sync2p u_free_sync (.clk(clk), .rst(rst), .i_lvl(i_free), .o_evt(w_free_evt));
  event_sync2p u_fire_sync (.clk(clk), .rst(rst), .i_lvl(i_fire), .o_evt(w_fire_evt));

  assign w_tmo_nxt = {1'b0, r_tmo} + 17'd1;
  assign w_inc     = (r_state == ST_DRIVE);
  assign w_dec     = w_fire_evt && (r_inflight != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_ptr           <= PTR_W'(N_REQ - 1);
      r_winner        <= '0;
      r_gnt           <= '0;
      r_drive         <= 1'b0;
      r_inflight      <= '0;
      r_tmo           <= '0;
      r_err_timeout   <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if ((|i_req) && (r_inflight < INFL_W'(MAX_INFLIGHT))) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (|i_req) begin
            r_winner <= rr_pick(i_req, r_ptr);
            r_state  <= ST_DRIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          r_drive <= ~r_drive;
          r_gnt   <= N_REQ'(1) << r_winner;
          r_ptr   <= r_winner;
          r_tmo   <= '0;
          r_state <= ST_WAIT_FREE;
        end
        ST_WAIT_FREE: begin
          if (w_free_evt) begin
            r_state <= ST_IDLE;
          end else if (w_tmo_nxt == 17'(TIMEOUT)) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_HALT;
          end else begin
            r_tmo <= w_tmo_nxt[15:0];
          end
        end
        ST_HALT: begin
          if (i_clr_err) begin
            r_err_timeout <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_inc && !w_dec)      r_inflight <= r_inflight + 1'b1;
      else if (!w_inc && w_dec) r_inflight <= r_inflight - 1'b1;

      // A fresh underflow outranks a clear arriving in the same cycle.
      if (w_fire_evt && (r_inflight == '0)) r_err_underflow <= 1'b1;
      else if (i_clr_err)                   r_err_underflow <= 1'b0;
    end
  end

`ifdef FIFO_LAST_SCHED_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if ((r_state == ST_DRIVE) && (int'(r_winner) == k) && (r_cnt[k] != '1))
          r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  assign o_grant_cnt = r_cnt;
`else
  assign o_grant_cnt = '0;
`endif

  assign o_gnt           = r_gnt;
  assign o_drive         = r_drive;
  assign o_inflight      = r_inflight;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_err_timeout   = r_err_timeout;
  assign o_err_underflow = r_err_underflow;
endmodule

// File: tb/tb_fifo_last_sched.sv
// tb/tb_fifo_last_sched.sv - directed and randomized checks of fifo_last_sched
`timescale 1ns/1ps
module tb_fifo_last_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  i_req = '0;
  logic [3:0]  o_gnt;
  logic        o_drive;
  logic        i_free = 1'b0;
  logic        i_fire = 1'b0;
  logic [3:0]  o_inflight;
  logic        o_busy, o_err_timeout, o_err_underflow;
  logic        i_clr_err = 1'b0;
  logic [63:0] o_grant_cnt;

  fifo_last_sched #(.N_REQ(4), .MAX_INFLIGHT(2), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .o_drive(o_drive),
    .i_free(i_free), .i_fire(i_fire), .o_inflight(o_inflight), .o_busy(o_busy),
    .o_err_timeout(o_err_timeout), .o_err_underflow(o_err_underflow),
    .i_clr_err(i_clr_err), .o_grant_cnt(o_grant_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic drv_last;
  int   mptr;
  int   mcnt [4];
  int   now = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int rr(input logic [3:0] req, input int ptr);
    for (int s = 1; s <= 4; s++)
      if (req[(ptr + s) % 4]) return (ptr + s) % 4;
    return -1;
  endfunction

  task automatic check_grant(input int exp);
    chk("gnt", {60'd0, o_gnt}, 64'(1) << exp);
    chk("drive_toggle", {63'd0, o_drive}, {63'd0, !drv_last});
    drv_last = !drv_last;
    mcnt[exp]++;
    mptr = exp;
  endtask

  task automatic wait_grant(input int exp);
    int n = 0;
    do begin tick(); n++; end while (o_gnt == '0 && n < 60);
    chk("grant_arrives", {63'd0, (o_gnt != '0)}, 64'd1);
    check_grant(exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; i_req = '0; i_free = 1'b0; i_fire = 1'b0; i_clr_err = 1'b0;
    ticks(2);
    rst = 1'b1;
    drv_last = 1'b0;
    mptr = 3;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    tick();
  endtask

  task automatic check_stats(input string tag);
    logic [63:0] e;
    e = '0;
`ifdef FIFO_LAST_SCHED_STATS_EN
    for (int k = 0; k < 4; k++) e[k*16 +: 16] = 16'(mcnt[k]);
`endif
    chk(tag, o_grant_cnt, e);
  endtask

  initial begin
    logic [3:0] mreq;
    int hit, ng, cyc, free_due, exp;
    int fire_q[$];

    ticks(2);
    chk("rst_gnt", {60'd0, o_gnt}, 64'd0);
    chk("rst_drive", {63'd0, o_drive}, 64'd0);
    chk("rst_inflight", {60'd0, o_inflight}, 64'd0);
    chk("rst_flags", {61'd0, o_busy, o_err_timeout, o_err_underflow}, 64'd0);
    chk("rst_cnt", o_grant_cnt, 64'd0);
    do_reset();

    // single requester, exact grant latency
    i_req = 4'b0001;
    ticks(2);
    chk("lat_early", {60'd0, o_gnt}, 64'd0);
    tick();
    check_grant(0);
    i_req = '0;
    chk("single_infl", {60'd0, o_inflight}, 64'd1);
    ticks(4); i_free = ~i_free; ticks(6);
    chk("single_idle", {63'd0, o_busy}, 64'd0);
    i_fire = ~i_fire; ticks(5);
    chk("single_fired", {60'd0, o_inflight}, 64'd0);

    // round robin from reset pointer
    do_reset();
    i_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % 4);
      if (g == 4) i_req = '0;
      ticks(3); i_free = ~i_free; ticks(2); i_fire = ~i_fire;
    end
    ticks(6);
    chk("rr_drained", {60'd0, o_inflight}, 64'd0);

    // credit limit
    i_req = 4'b0001;
    wait_grant(0); ticks(3); i_free = ~i_free;
    wait_grant(0); ticks(3); i_free = ~i_free;
    ticks(12);
    chk("credit_infl", {60'd0, o_inflight}, 64'd2);
    chk("credit_busy", {63'd0, o_busy}, 64'd0);
    chk("credit_nodrive", {63'd0, o_drive}, {63'd0, drv_last});
    i_fire = ~i_fire;
    wait_grant(0);
    i_req = '0;
    ticks(3); i_free = ~i_free; ticks(6);
    chk("credit_refill", {60'd0, o_inflight}, 64'd2);
    i_fire = ~i_fire; ticks(2); i_fire = ~i_fire; ticks(6);
    chk("credit_drained", {60'd0, o_inflight}, 64'd0);

    // underflow, then fire coinciding with DRIVE
    i_fire = ~i_fire; ticks(5);
    chk("uflow_set", {63'd0, o_err_underflow}, 64'd1);
    chk("uflow_infl", {60'd0, o_inflight}, 64'd0);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0; tick();
    chk("uflow_clr", {63'd0, o_err_underflow}, 64'd0);
    i_req = 4'b0001;
    wait_grant(0);
    i_req = '0;
    ticks(3); i_free = ~i_free; ticks(6);
    i_req = 4'b0001; i_fire = ~i_fire;
    ticks(3);
    check_grant(0);
    chk("simul_infl", {60'd0, o_inflight}, 64'd1);
    i_req = '0;
    ticks(3); i_free = ~i_free; ticks(2); i_fire = ~i_fire; ticks(6);
    chk("simul_drained", {60'd0, o_inflight}, 64'd0);

    // timeout and HALT
    i_req = 4'b0001;
    wait_grant(0);
    hit = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (o_err_timeout && hit == 0) hit = c;
    end
    chk("tmo_latency", 64'(hit), 64'd10);
    ticks(8);
    chk("halt_nodrive", {63'd0, o_drive}, {63'd0, drv_last});
    chk("halt_busy", {63'd0, o_busy}, 64'd1);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    chk("tmo_clr", {63'd0, o_err_timeout}, 64'd0);
    wait_grant(0);
    i_req = '0;
    chk("post_halt_infl", {60'd0, o_inflight}, 64'd2);
    ticks(3); i_free = ~i_free; ticks(2); i_fire = ~i_fire; ticks(2); i_fire = ~i_fire; ticks(6);
    chk("post_halt_drained", {60'd0, o_inflight}, 64'd0);

    // asynchronous reset while waiting for free
    i_req = 4'b0100;
    wait_grant(2);
    i_req = '0;
    rst = 1'b0;
    #1;
    chk("arst_gnt", {60'd0, o_gnt}, 64'd0);
    chk("arst_drive", {63'd0, o_drive}, 64'd0);
    chk("arst_infl", {60'd0, o_inflight}, 64'd0);
    chk("arst_flags", {61'd0, o_busy, o_err_timeout, o_err_underflow}, 64'd0);
    chk("arst_cnt", o_grant_cnt, 64'd0);
    do_reset();

    for (int g = 0; g < 5; g++) begin
      i_req = 4'b0100;
      wait_grant(2);
      i_req = '0;
      ticks(3); i_free = ~i_free; ticks(2); i_fire = ~i_fire; ticks(6);
    end
    check_stats("stats_req2");

    // randomized traffic against a behavioural FIFO stage
    mreq = 4'(1 << $urandom_range(0, 3));
    i_req = mreq;
    ng = 0; cyc = 0; free_due = -1;
    while (ng < 40 && cyc < 4000) begin
      tick(); cyc++;
      chk("infl_max", {63'd0, (o_inflight <= 4'd2)}, 64'd1);
      if (o_gnt != '0) begin
        exp = rr(mreq, mptr);
        check_grant(exp);
        ng++;
        free_due = now + int'($urandom_range(1, 5));
        fire_q.push_back(now + int'($urandom_range(6, 14)));
        mreq = (mreq & ~(4'(1) << exp)) | 4'($urandom_range(0, 15));
        if (mreq == '0) mreq = 4'(1 << $urandom_range(0, 3));
        i_req = mreq;
      end
      if (now == free_due) i_free = ~i_free;
      foreach (fire_q[i]) begin
        if (fire_q[i] <= now) begin
          i_fire = ~i_fire;
          fire_q.delete(i);
          break;
        end
      end
    end
    chk("rand_progress", 64'(ng), 64'd40);
    i_req = '0;
    cyc = 0;
    while ((fire_q.size() != 0 || now <= free_due) && cyc < 200) begin
      tick(); cyc++;
      if (now == free_due) i_free = ~i_free;
      foreach (fire_q[i]) begin
        if (fire_q[i] <= now) begin
          i_fire = ~i_fire;
          fire_q.delete(i);
          break;
        end
      end
    end
    ticks(8);
    chk("rand_drained", {60'd0, o_inflight}, 64'd0);
    chk("rand_flags", {61'd0, o_busy, o_err_timeout, o_err_underflow}, 64'd0);
    check_stats("stats_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
